// File: rtl/lint_arb_pkg.sv
// Shared types and constants for the two-master lint debug arbiter.
//   master_id_t : 1-bit id of the master that issued a lint transaction
//   MASTER_JTAG : id of the JTAG debug path (master 0)
//   MASTER_AUX  : id of the second debug requester, e.g. SPI slave (master 1)
package lint_arb_pkg;

   typedef logic master_id_t;

   localparam master_id_t MASTER_JTAG = 1'b0;
   localparam master_id_t MASTER_AUX  = 1'b1;

endpackage

// File: rtl/lint_arb_id_fifo.sv
// In-order FIFO of master ids, one entry per granted-but-unanswered transaction.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i, push_id_i : enqueue the id of a newly granted request
//   pop_i           : dequeue the head when its response arrives
//   full_o, empty_o : occupancy flags
//   head_o          : id at the head (owner of the next response)
//   count_o         : number of stored ids
module lint_arb_id_fifo
   import lint_arb_pkg::*;
#(
   parameter int unsigned  Depth = 2,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  master_id_t      push_id_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output master_id_t      head_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   master_id_t            mem_q [Depth];
   logic       [PtrW-1:0] wptr_q, wptr_d;
   logic       [PtrW-1:0] rptr_q, rptr_d;
   logic       [CntW-1:0] count_q, count_d;
   logic                  push_en, pop_en;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Guard against overflow/underflow even if the caller misbehaves.
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      // Pointers wrap explicitly so non-power-of-two depths work.
      if (push_en) begin
         wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop_en) begin
         rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push_en) begin
         mem_q[wptr_q] <= push_id_i;
      end
   end

endmodule

// File: rtl/lint_debug_arbiter.sv
// Round-robin arbiter sharing one lint master port between the JTAG debug path
// (m0) and a second debug requester (m1). Responses are routed back in issue
// order using an id FIFO.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   mX_req/add/wen/wdata/be_i : request from master X (wen: 1 = read)
//   mX_gnt_o            : grant to master X
//   mX_r_valid/rdata/opc_o : response to master X
//   s_req/add/wen/wdata/be_o, s_gnt_i : shared request to the interconnect
//   s_r_valid/rdata/opc_i : interconnect response
//   err_o               : sticky, a response arrived with nothing outstanding
module lint_debug_arbiter
   import lint_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_OUTST  = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    m0_req_i,
   input  logic [ADDR_WIDTH-1:0]   m0_add_i,
   input  logic                    m0_wen_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   output logic                    m0_gnt_o,
   output logic                    m0_r_valid_o,
   output logic [DATA_WIDTH-1:0]   m0_r_rdata_o,
   output logic                    m0_r_opc_o,
   input  logic                    m1_req_i,
   input  logic [ADDR_WIDTH-1:0]   m1_add_i,
   input  logic                    m1_wen_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   output logic                    m1_gnt_o,
   output logic                    m1_r_valid_o,
   output logic [DATA_WIDTH-1:0]   m1_r_rdata_o,
   output logic                    m1_r_opc_o,
   output logic                    s_req_o,
   output logic [ADDR_WIDTH-1:0]   s_add_o,
   output logic                    s_wen_o,
   output logic [DATA_WIDTH-1:0]   s_wdata_o,
   output logic [DATA_WIDTH/8-1:0] s_be_o,
   input  logic                    s_gnt_i,
   input  logic                    s_r_valid_i,
   input  logic [DATA_WIDTH-1:0]   s_r_rdata_i,
   input  logic                    s_r_opc_i,
   output logic                    err_o
);

   localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

   master_id_t            prio_q, prio_d;
   logic                  err_q, err_d;
   logic                  elig0, elig1;
   logic                  sel_valid;
   master_id_t            sel_id;
   logic                  handshake;
   logic                  rsp_pop;
   logic                  fifo_full, fifo_empty;
   master_id_t            fifo_head;
   logic       [CntW-1:0] fifo_cnt;

   // Full is taken from the registered count, so a same-cycle pop does not
   // open a slot until the next cycle. Reset forces every output to 0.
   assign elig0 = m0_req_i & ~fifo_full & ~rst_i;
   assign elig1 = m1_req_i & ~fifo_full & ~rst_i;

   assign sel_valid = elig0 | elig1;
   assign sel_id    = (elig0 & elig1) ? prio_q : (elig1 ? MASTER_AUX : MASTER_JTAG);
   assign handshake = sel_valid & s_gnt_i;

   always_comb begin
      s_req_o   = 1'b0;
      s_add_o   = '0;
      s_wen_o   = 1'b0;
      s_wdata_o = '0;
      s_be_o    = '0;
      if (sel_valid) begin
         s_req_o = 1'b1;
         if (sel_id == MASTER_AUX) begin
            s_add_o   = m1_add_i;
            s_wen_o   = m1_wen_i;
            s_wdata_o = m1_wdata_i;
            s_be_o    = m1_be_i;
         end else begin
            s_add_o   = m0_add_i;
            s_wen_o   = m0_wen_i;
            s_wdata_o = m0_wdata_i;
            s_be_o    = m0_be_i;
         end
      end
   end

   assign m0_gnt_o = handshake & (sel_id == MASTER_JTAG);
   assign m1_gnt_o = handshake & (sel_id == MASTER_AUX);

   // Response routing: the FIFO head owns the current response.
   assign rsp_pop = s_r_valid_i & ~fifo_empty & ~rst_i;

   always_comb begin
      m0_r_valid_o = 1'b0;
      m0_r_rdata_o = '0;
      m0_r_opc_o   = 1'b0;
      m1_r_valid_o = 1'b0;
      m1_r_rdata_o = '0;
      m1_r_opc_o   = 1'b0;
      if (rsp_pop) begin
         if (fifo_head == MASTER_AUX) begin
            m1_r_valid_o = 1'b1;
            m1_r_rdata_o = s_r_rdata_i;
            m1_r_opc_o   = s_r_opc_i;
         end else begin
            m0_r_valid_o = 1'b1;
            m0_r_rdata_o = s_r_rdata_i;
            m0_r_opc_o   = s_r_opc_i;
         end
      end
   end

   // Priority only moves on a handshake so a stalled winner keeps its slot.
   assign prio_d = handshake ? ~sel_id : prio_q;
   assign err_d  = err_q | (s_r_valid_i & fifo_empty);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= MASTER_JTAG;
         err_q  <= 1'b0;
      end else begin
         prio_q <= prio_d;
         err_q  <= err_d;
      end
   end

   assign err_o = err_q & ~rst_i;

   lint_arb_id_fifo #(
      .Depth (MAX_OUTST)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (handshake),
      .push_id_i (sel_id),
      .pop_i     (rsp_pop),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .head_o    (fifo_head),
      .count_o   (fifo_cnt)
   );

   cnt_bounded_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                   fifo_cnt <= CntW'(MAX_OUTST));

endmodule

// File: tb/tb_lint_debug_arbiter.sv
// Directed self-checking bench for lint_debug_arbiter (MAX_OUTST = 2).
module tb_lint_debug_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m1_req_i;
   logic [31:0] m0_add_i, m1_add_i;
   logic        m0_wen_i, m1_wen_i;
   logic [31:0] m0_wdata_i, m1_wdata_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic        m0_gnt_o, m1_gnt_o;
   logic        m0_r_valid_o, m1_r_valid_o;
   logic [31:0] m0_r_rdata_o, m1_r_rdata_o;
   logic        m0_r_opc_o, m1_r_opc_o;
   logic        s_req_o;
   logic [31:0] s_add_o;
   logic        s_wen_o;
   logic [31:0] s_wdata_o;
   logic [3:0]  s_be_o;
   logic        s_gnt_i;
   logic        s_r_valid_i;
   logic [31:0] s_r_rdata_i;
   logic        s_r_opc_i;
   logic        err_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   lint_debug_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MAX_OUTST  (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .m0_req_i     (m0_req_i),
      .m0_add_i     (m0_add_i),
      .m0_wen_i     (m0_wen_i),
      .m0_wdata_i   (m0_wdata_i),
      .m0_be_i      (m0_be_i),
      .m0_gnt_o     (m0_gnt_o),
      .m0_r_valid_o (m0_r_valid_o),
      .m0_r_rdata_o (m0_r_rdata_o),
      .m0_r_opc_o   (m0_r_opc_o),
      .m1_req_i     (m1_req_i),
      .m1_add_i     (m1_add_i),
      .m1_wen_i     (m1_wen_i),
      .m1_wdata_i   (m1_wdata_i),
      .m1_be_i      (m1_be_i),
      .m1_gnt_o     (m1_gnt_o),
      .m1_r_valid_o (m1_r_valid_o),
      .m1_r_rdata_o (m1_r_rdata_o),
      .m1_r_opc_o   (m1_r_opc_o),
      .s_req_o      (s_req_o),
      .s_add_o      (s_add_o),
      .s_wen_o      (s_wen_o),
      .s_wdata_o    (s_wdata_o),
      .s_be_o       (s_be_o),
      .s_gnt_i      (s_gnt_i),
      .s_r_valid_i  (s_r_valid_i),
      .s_r_rdata_i  (s_r_rdata_i),
      .s_r_opc_i    (s_r_opc_i),
      .err_o        (err_o)
   );

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      m0_req_i = 0; m0_add_i = '0; m0_wen_i = 0; m0_wdata_i = '0; m0_be_i = '0;
      m1_req_i = 0; m1_add_i = '0; m1_wen_i = 0; m1_wdata_i = '0; m1_be_i = '0;
      s_gnt_i = 0; s_r_valid_i = 0; s_r_rdata_i = '0; s_r_opc_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1'b1;
      m0_req_i = 1; m0_add_i = 32'h1234; s_gnt_i = 1; s_r_valid_i = 1;
      #1;
      n_chk++; if (s_req_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_s_req: got %0b want 0", s_req_o); end
      n_chk++; if (m0_gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_m0_gnt: got %0b want 0", m0_gnt_o); end
      n_chk++; if (m0_r_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_m0_r_valid: got %0b want 0", m0_r_valid_o); end
      n_chk++; if (s_add_o !== 32'h0) begin n_fail++;
         $display("FAIL reset_s_add: got %0h want 0", s_add_o); end
      step();
      step();
      clear_inputs();
      rst_i = 1'b0;
      step();
      n_chk++; if (err_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_err: got %0b want 0", err_o); end
   endtask

   task automatic test_single();
      do_reset();
      m0_req_i = 1; m0_add_i = 32'h1A10_0000; m0_wen_i = 1; m0_be_i = 4'hF; s_gnt_i = 1;
      #1;
      n_chk++; if (m0_gnt_o !== 1'b1) begin n_fail++;
         $display("FAIL single_m0_gnt: got %0b want 1", m0_gnt_o); end
      n_chk++; if (m1_gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL single_m1_gnt: got %0b want 0", m1_gnt_o); end
      n_chk++; if (s_add_o !== 32'h1A10_0000) begin n_fail++;
         $display("FAIL single_s_add: got %0h want 1a100000", s_add_o); end
      n_chk++; if (s_wen_o !== 1'b1) begin n_fail++;
         $display("FAIL single_s_wen: got %0b want 1", s_wen_o); end
      step();
      m0_req_i = 0; s_gnt_i = 0; s_r_valid_i = 1; s_r_rdata_i = 32'hDEAD_BEEF;
      #1;
      n_chk++; if (m0_r_valid_o !== 1'b1) begin n_fail++;
         $display("FAIL single_m0_r_valid: got %0b want 1", m0_r_valid_o); end
      n_chk++; if (m0_r_rdata_o !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL single_m0_rdata: got %0h want deadbeef", m0_r_rdata_o); end
      n_chk++; if (m1_r_valid_o !== 1'b0 || m1_r_rdata_o !== 32'h0) begin n_fail++;
         $display("FAIL single_m1_rsp: got valid %0b data %0h want 0/0",
                  m1_r_valid_o, m1_r_rdata_o); end
      step();
      s_r_valid_i = 0;
      #1;
      n_chk++; if (err_o !== 1'b0) begin n_fail++;
         $display("FAIL single_err: got %0b want 0", err_o); end
   endtask

   task automatic test_contention();
      do_reset();
      m0_req_i = 1; m0_add_i = 32'h1000; m0_wen_i = 1; m0_be_i = 4'hF;
      m1_req_i = 1; m1_add_i = 32'h2000; m1_wen_i = 0; m1_wdata_i = 32'hCAFE_0001;
      m1_be_i = 4'h3;
      s_gnt_i = 1;
      for (int i = 0; i < 4; i++) begin
         s_r_valid_i = (i > 0);
         s_r_rdata_i = 32'h100 + i;
         #1;
         if ((i % 2) == 0) begin
            n_chk++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_fail++;
               $display("FAIL cont_gnt%0d: got m0 %0b m1 %0b want 1/0", i, m0_gnt_o, m1_gnt_o); end
            n_chk++; if (s_add_o !== 32'h1000 || s_wen_o !== 1'b1 || s_be_o !== 4'hF) begin
               n_fail++;
               $display("FAIL cont_mux%0d: got %0h/%0b/%0h want 1000/1/f",
                        i, s_add_o, s_wen_o, s_be_o); end
         end else begin
            n_chk++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b1) begin n_fail++;
               $display("FAIL cont_gnt%0d: got m0 %0b m1 %0b want 0/1", i, m0_gnt_o, m1_gnt_o); end
            n_chk++; if (s_add_o !== 32'h2000 || s_wen_o !== 1'b0 || s_be_o !== 4'h3 ||
                         s_wdata_o !== 32'hCAFE_0001) begin n_fail++;
               $display("FAIL cont_mux%0d: got %0h/%0b/%0h/%0h want 2000/0/3/cafe0001",
                        i, s_add_o, s_wen_o, s_be_o, s_wdata_o); end
         end
         if (i > 0) begin
            // Response i answers the request issued in cycle i-1.
            if (((i - 1) % 2) == 0) begin
               n_chk++; if (m0_r_valid_o !== 1'b1 || m0_r_rdata_o !== 32'h100 + i ||
                            m1_r_valid_o !== 1'b0) begin n_fail++;
                  $display("FAIL cont_rsp%0d: got m0 %0b/%0h m1 %0b want m0 1/%0h",
                           i, m0_r_valid_o, m0_r_rdata_o, m1_r_valid_o, 32'h100 + i); end
            end else begin
               n_chk++; if (m1_r_valid_o !== 1'b1 || m1_r_rdata_o !== 32'h100 + i ||
                            m0_r_valid_o !== 1'b0) begin n_fail++;
                  $display("FAIL cont_rsp%0d: got m1 %0b/%0h m0 %0b want m1 1/%0h",
                           i, m1_r_valid_o, m1_r_rdata_o, m0_r_valid_o, 32'h100 + i); end
            end
         end
         step();
      end
      m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0;
      s_r_valid_i = 1; s_r_rdata_i = 32'h104;
      #1;
      n_chk++; if (m1_r_valid_o !== 1'b1 || m1_r_rdata_o !== 32'h104 ||
                   m0_r_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL cont_rsp_last: got m1 %0b/%0h m0 %0b want 1/104/0",
                  m1_r_valid_o, m1_r_rdata_o, m0_r_valid_o); end
      step();
      s_r_valid_i = 0;
      #1;
      n_chk++; if (err_o !== 1'b0) begin n_fail++;
         $display("FAIL cont_err: got %0b want 0", err_o); end
   endtask

   task automatic test_stall();
      do_reset();
      m0_req_i = 1; m0_add_i = 32'hA0; m1_req_i = 1; m1_add_i = 32'hB0; s_gnt_i = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_chk++; if (s_req_o !== 1'b1 || s_add_o !== 32'hA0 ||
                      m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin n_fail++;
            $display("FAIL stall%0d: got req %0b add %0h gnt %0b%0b want 1/a0/00",
                     i, s_req_o, s_add_o, m0_gnt_o, m1_gnt_o); end
         step();
      end
      s_gnt_i = 1;
      #1;
      n_chk++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL stall_first_gnt: got %0b%0b want m0 only", m0_gnt_o, m1_gnt_o); end
      step();
      #1;
      n_chk++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0 || s_add_o !== 32'hB0) begin
         n_fail++;
         $display("FAIL stall_second_gnt: got %0b%0b add %0h want m1/b0",
                  m0_gnt_o, m1_gnt_o, s_add_o); end
      step();
      m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_r_valid_i = 1; s_r_rdata_i = 32'h11;
      #1;
      n_chk++; if (m0_r_valid_o !== 1'b1 || m1_r_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL stall_rsp0: got %0b%0b want m0", m0_r_valid_o, m1_r_valid_o); end
      step();
      s_r_rdata_i = 32'h22;
      #1;
      n_chk++; if (m1_r_valid_o !== 1'b1 || m1_r_rdata_o !== 32'h22) begin n_fail++;
         $display("FAIL stall_rsp1: got %0b/%0h want 1/22", m1_r_valid_o, m1_r_rdata_o); end
      step();
      s_r_valid_i = 0;
   endtask

   task automatic test_full();
      do_reset();
      m0_req_i = 1; m0_add_i = 32'hC0; s_gnt_i = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_chk++; if (m0_gnt_o !== 1'b1) begin n_fail++;
            $display("FAIL full_fill%0d: got %0b want 1", i, m0_gnt_o); end
         step();
      end
      #1;
      n_chk++; if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL full_block: got req %0b gnt %0b want 0/0", s_req_o, m0_gnt_o); end
      step();
      s_r_valid_i = 1; s_r_rdata_i = 32'h55;
      #1;
      n_chk++; if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL full_pop_cycle: got req %0b gnt %0b want 0/0", s_req_o, m0_gnt_o); end
      n_chk++; if (m0_r_valid_o !== 1'b1 || m0_r_rdata_o !== 32'h55) begin n_fail++;
         $display("FAIL full_rsp: got %0b/%0h want 1/55", m0_r_valid_o, m0_r_rdata_o); end
      step();
      s_r_valid_i = 0;
      #1;
      n_chk++; if (s_req_o !== 1'b1 || m0_gnt_o !== 1'b1) begin n_fail++;
         $display("FAIL full_next: got req %0b gnt %0b want 1/1", s_req_o, m0_gnt_o); end
      step();
      m0_req_i = 0; s_gnt_i = 0; s_r_valid_i = 1;
      step();
      step();
      s_r_valid_i = 0;
      #1;
      n_chk++; if (err_o !== 1'b0) begin n_fail++;
         $display("FAIL full_drain_err: got %0b want 0", err_o); end
   endtask

   task automatic test_unexpected();
      do_reset();
      s_r_valid_i = 1; s_r_rdata_i = 32'h77;
      #1;
      n_chk++; if (m0_r_valid_o !== 1'b0 || m1_r_valid_o !== 1'b0 ||
                   m0_r_rdata_o !== 32'h0) begin n_fail++;
         $display("FAIL unexp_route: got %0b%0b data %0h want 00/0",
                  m0_r_valid_o, m1_r_valid_o, m0_r_rdata_o); end
      step();
      s_r_valid_i = 0;
      #1;
      n_chk++; if (err_o !== 1'b1) begin n_fail++;
         $display("FAIL unexp_err: got %0b want 1", err_o); end
      step();
      n_chk++; if (err_o !== 1'b1) begin n_fail++;
         $display("FAIL unexp_sticky: got %0b want 1", err_o); end
      rst_i = 1;
      #1;
      n_chk++; if (err_o !== 1'b0) begin n_fail++;
         $display("FAIL unexp_in_reset: got %0b want 0", err_o); end
      step();
      rst_i = 0;
      #1;
      n_chk++; if (err_o !== 1'b0) begin n_fail++;
         $display("FAIL unexp_cleared: got %0b want 0", err_o); end
      m1_req_i = 1; m1_add_i = 32'hE0; s_gnt_i = 1;
      #1;
      n_chk++; if (m1_gnt_o !== 1'b1) begin n_fail++;
         $display("FAIL midrst_gnt: got %0b want 1", m1_gnt_o); end
      step();
      m1_req_i = 0; s_gnt_i = 0; rst_i = 1;
      step();
      rst_i = 0; s_r_valid_i = 1; s_r_rdata_i = 32'h99;
      #1;
      n_chk++; if (m1_r_valid_o !== 1'b0 || m0_r_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL midrst_route: got %0b%0b want 00", m0_r_valid_o, m1_r_valid_o); end
      step();
      s_r_valid_i = 0;
      #1;
      n_chk++; if (err_o !== 1'b1) begin n_fail++;
         $display("FAIL midrst_err: got %0b want 1", err_o); end
   endtask

   initial begin
      clear_inputs();
      rst_i = 1'b1;
      #2;
      test_reset();
      test_single();
      test_contention();
      test_stall();
      test_full();
      test_unexpected();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
